// File: rtl/bus_read_pkg.sv
// Shared definitions for the bus read controller.
//   bus_state_e : FSM state encoding (IDLE / SETTLE / RESP)
//   CNT_BITS    : width of the settle counter (settle range 1..15)
package bus_read_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } bus_state_e;

   localparam int unsigned CNT_BITS = 4;

endpackage : bus_read_pkg

// File: rtl/bus_read_controller.sv
// Read-side master for the shared tri-state data bus.
// Accepts a read request naming one bus source, pulls that source's chip select
// low for SettleCycles tick periods, samples the bus, and returns the word on a
// valid/ready response port. Out-of-range selects return an error response
// without touching any chip select.
// Ports:
//   Clock, Reset       : rising-edge clock, asynchronous active-high reset
//   Tick               : clock enable; state advances only on Clock edges with Tick=1
//   ReqValid/ReqSel    : read request and source index
//   ReqReady           : high only while idle (combinational from state)
//   CsN                : per-source select, active low, at most one bit low
//   BusIn              : shared bus value
//   RespValid/RespData/RespErr/RespReady : response handshake
module bus_read_controller
   import bus_read_pkg::*;
#(
   parameter int unsigned NrOfBits     = 8,
   parameter int unsigned NrOfSources  = 4,
   parameter int unsigned SelBits      = 2,
   parameter int unsigned SettleCycles = 1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Tick,
   input  logic                   ReqValid,
   input  logic [SelBits-1:0]     ReqSel,
   output logic                   ReqReady,
   output logic [NrOfSources-1:0] CsN,
   input  logic [NrOfBits-1:0]    BusIn,
   output logic                   RespValid,
   output logic [NrOfBits-1:0]    RespData,
   output logic                   RespErr,
   input  logic                   RespReady
);

   localparam logic [CNT_BITS-1:0] SETTLE_LOAD = CNT_BITS'(SettleCycles);

   bus_state_e                 state_q;
   logic [CNT_BITS-1:0]        cnt_q;
   logic [NrOfSources-1:0]     csn_q;
   logic                       resp_valid_q;
   logic [NrOfBits-1:0]        resp_data_q;
   logic                       resp_err_q;

   logic                       sel_ok;
   logic [NrOfSources-1:0]     sel_dec_n;

   assign sel_ok = (32'(ReqSel) < NrOfSources);

   // Active-low one-hot decode of the request; loaded into csn_q on accept so
   // CsN comes straight from a flop and cannot glitch.
   always_comb begin
      sel_dec_n = '1;
      for (int unsigned i = 0; i < NrOfSources; i++) begin
         sel_dec_n[i] = (32'(ReqSel) != i);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         csn_q        <= '1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else if (Tick) begin
         case (state_q)
            ST_IDLE: begin
               if (ReqValid) begin
                  if (sel_ok) begin
                     csn_q   <= sel_dec_n;
                     cnt_q   <= SETTLE_LOAD;
                     state_q <= ST_SETTLE;
                  end else begin
                     resp_data_q  <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= ST_RESP;
                  end
               end
            end
            ST_SETTLE: begin
               if (cnt_q == CNT_BITS'(1)) begin
                  resp_data_q  <= BusIn;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  csn_q        <= '1;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_BITS'(1);
               end
            end
            ST_RESP: begin
               if (RespReady) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               csn_q        <= '1;
               resp_valid_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign ReqReady  = (state_q == ST_IDLE);
   assign CsN       = csn_q;
   assign RespValid = resp_valid_q;
   assign RespData  = resp_data_q;
   assign RespErr   = resp_err_q;

endmodule : bus_read_controller

// File: tb/tb_bus_read_controller.sv
// Directed self-checking bench for bus_read_controller.
// Three instances: u_d1 (defaults), u_d3 (SettleCycles=3), u_d4 (SelBits=3).
module tb_bus_read_controller;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Tick;
   logic [7:0] BusIn;
   logic       RespReady;

   logic       rv1, rv3, rv4;
   logic [1:0] sel1, sel3;
   logic [2:0] sel4;

   logic       rr1, rr3, rr4;
   logic [3:0] cs1, cs3, cs4;
   logic       vl1, vl3, vl4;
   logic [7:0] dt1, dt3, dt4;
   logic       er1, er3, er4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clock = ~Clock;

   bus_read_controller u_d1 (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .ReqValid(rv1), .ReqSel(sel1),
      .ReqReady(rr1), .CsN(cs1), .BusIn(BusIn), .RespValid(vl1), .RespData(dt1),
      .RespErr(er1), .RespReady(RespReady));

   bus_read_controller #(.SettleCycles(3)) u_d3 (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .ReqValid(rv3), .ReqSel(sel3),
      .ReqReady(rr3), .CsN(cs3), .BusIn(BusIn), .RespValid(vl3), .RespData(dt3),
      .RespErr(er3), .RespReady(RespReady));

   bus_read_controller #(.NrOfSources(4), .SelBits(3)) u_d4 (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .ReqValid(rv4), .ReqSel(sel4),
      .ReqReady(rr4), .CsN(cs4), .BusIn(BusIn), .RespValid(vl4), .RespData(dt4),
      .RespErr(er4), .RespReady(RespReady));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then sample/drive on the following falling edge.
   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; Tick = 1'b1; BusIn = 8'h00; RespReady = 1'b0;
      rv1 = 1'b0; rv3 = 1'b0; rv4 = 1'b0;
      sel1 = '0; sel3 = '0; sel4 = '0;
      step(); step();

      // Reset state
      chk("rst_csn",   32'(cs1), 32'hF);
      chk("rst_valid", 32'(vl1), 32'h0);
      chk("rst_err",   32'(er1), 32'h0);
      chk("rst_data",  32'(dt1), 32'h0);
      chk("rst_ready", 32'(rr1), 32'h1);
      Reset = 1'b0;
      step();

      // Default settle: sel 2, one-cycle select, sample A5
      rv1 = 1'b1; sel1 = 2'd2; BusIn = 8'hA5;
      step();
      rv1 = 1'b0;
      chk("s1_csn_low",  32'(cs1), 32'hB);
      chk("s1_ready_lo", 32'(rr1), 32'h0);
      chk("s1_valid_lo", 32'(vl1), 32'h0);
      step();
      chk("s1_valid", 32'(vl1), 32'h1);
      chk("s1_data",  32'(dt1), 32'hA5);
      chk("s1_err",   32'(er1), 32'h0);
      chk("s1_csn_hi", 32'(cs1), 32'hF);
      RespReady = 1'b1;
      step();
      RespReady = 1'b0;
      chk("s1_done_valid", 32'(vl1), 32'h0);
      chk("s1_done_data",  32'(dt1), 32'hA5);
      chk("s1_done_ready", 32'(rr1), 32'h1);

      // Backpressure: response held while RespReady=0, new requests refused
      rv1 = 1'b1; sel1 = 2'd1; BusIn = 8'h3C;
      step();
      rv1 = 1'b0;
      step();
      chk("bp_valid0", 32'(vl1), 32'h1);
      chk("bp_data0",  32'(dt1), 32'h3C);
      for (int i = 0; i < 5; i++) begin
         BusIn = ~BusIn; rv1 = 1'b1; sel1 = 2'd0;
         step();
         chk("bp_valid", 32'(vl1), 32'h1);
         chk("bp_data",  32'(dt1), 32'h3C);
         chk("bp_ready", 32'(rr1), 32'h0);
         chk("bp_csn",   32'(cs1), 32'hF);
      end
      rv1 = 1'b0; RespReady = 1'b1;
      step();
      RespReady = 1'b0;
      chk("bp_release", 32'(vl1), 32'h0);

      // Back-to-back reads sel 1 then sel 3 with RespReady held high
      RespReady = 1'b1; BusIn = 8'h5A; rv1 = 1'b1; sel1 = 2'd1;
      step();
      sel1 = 2'd3;
      chk("b2b_cs_a", 32'(cs1), 32'hD);
      step();
      chk("b2b_cs_b", 32'(cs1), 32'hF);
      chk("b2b_d_a",  32'(dt1), 32'h5A);
      BusIn = 8'hC3;
      step();
      chk("b2b_cs_c", 32'(cs1), 32'hF);
      chk("b2b_rdy",  32'(rr1), 32'h1);
      step();
      rv1 = 1'b0;
      chk("b2b_cs_d", 32'(cs1), 32'h7);
      chk("b2b_onehot", 32'($countones(~cs1) <= 1), 32'h1);
      step();
      chk("b2b_cs_e", 32'(cs1), 32'hF);
      chk("b2b_d_b",  32'(dt1), 32'hC3);
      step();
      RespReady = 1'b0;
      chk("b2b_idle", 32'(rr1), 32'h1);

      // Out-of-range select on a 3-bit select instance: last legal index first
      rv4 = 1'b1; sel4 = 3'd3; BusIn = 8'hFF;
      step();
      rv4 = 1'b0;
      chk("oor_leg_cs", 32'(cs4), 32'h7);
      step();
      chk("oor_leg_d", 32'(dt4), 32'hFF);
      RespReady = 1'b1;
      step();
      RespReady = 1'b0;
      rv4 = 1'b1; sel4 = 3'd5;
      step();
      rv4 = 1'b0;
      chk("oor_cs",    32'(cs4), 32'hF);
      chk("oor_valid", 32'(vl4), 32'h1);
      chk("oor_err",   32'(er4), 32'h1);
      chk("oor_data",  32'(dt4), 32'h0);
      RespReady = 1'b1;
      step();
      RespReady = 1'b0;
      chk("oor_done", 32'(rr4), 32'h1);

      // SettleCycles=3 with Tick every second clock
      Tick = 1'b1; rv3 = 1'b1; sel3 = 2'd0; BusIn = 8'h10;
      step();                      // accept
      rv3 = 1'b0; Tick = 1'b0;
      chk("t3_cs_acc", 32'(cs3), 32'hE);
      step();                      // no tick
      chk("t3_cs_nt",  32'(cs3), 32'hE);
      Tick = 1'b1;
      step();                      // tick 1
      Tick = 1'b0;
      step();
      BusIn = 8'h20; Tick = 1'b1;
      step();                      // tick 2: not sampled
      chk("t3_cs_t2",   32'(cs3), 32'hE);
      chk("t3_vld_t2",  32'(vl3), 32'h0);
      Tick = 1'b0;
      step();
      BusIn = 8'h30; Tick = 1'b1;
      step();                      // tick 3: sampled
      chk("t3_valid", 32'(vl3), 32'h1);
      chk("t3_data",  32'(dt3), 32'h30);
      chk("t3_cs_hi", 32'(cs3), 32'hF);
      Tick = 1'b0; RespReady = 1'b1;
      step();                      // no tick: handshake ignored
      chk("t3_hold", 32'(vl3), 32'h1);
      Tick = 1'b1;
      step();
      RespReady = 1'b0;
      chk("t3_done", 32'(vl3), 32'h0);

      // Reset asserted mid-SETTLE releases CsN immediately
      rv3 = 1'b1; sel3 = 2'd2;
      step();
      rv3 = 1'b0;
      chk("mr_cs_low", 32'(cs3), 32'hB);
      Reset = 1'b1;
      #1;
      chk("mr_cs_async", 32'(cs3), 32'hF);
      chk("mr_valid",    32'(vl3), 32'h0);
      step();
      Reset = 1'b0;
      step(); step(); step(); step();
      chk("mr_after_valid", 32'(vl3), 32'h0);
      chk("mr_after_ready", 32'(rr3), 32'h1);
      chk("mr_after_cs",    32'(cs3), 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_bus_read_controller
